// File: rtl/pwm_sequencer_pkg.sv
// Shared types and helpers for the PWM sequencer: FSM state encoding and
// the per-channel phase offset calculation.
package pwm_sequencer_pkg;

    // State codes are visible on the state port, so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    // Reset preload for channel k: k*phase folded into one period.
    function automatic int unsigned phase_offset(
        input int unsigned k,
        input int unsigned phase,
        input int unsigned period
    );
        return (k * phase) % (period + 1);
    endfunction

endpackage

// File: rtl/pwm_sequencer_channel.sv
// One PWM output: a free-running wrapping counter preloaded with its phase
// offset, and a registered compare against the shared applied duty.
module pwm_channel
    import pwm_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PERIOD = 255,
    parameter int unsigned INIT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty,
    output logic             out
);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(INIT);

    logic [WIDTH-1:0] cnt;

    // Phase counter: 0..PERIOD, wraps, starts at the channel's offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CNT_INIT;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Registered compare keeps the pin free of combinational glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= (cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer top: main period counter, ramp divider, button-driven FSM,
// target/applied duty registers and CHANNELS phase-shifted PWM outputs.
module pwm_sequencer
    import pwm_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD   = 255,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PHASE    = 0,
    parameter int unsigned STEP     = 16,
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    output logic [CHANNELS-1:0] pwm,
    output logic [WIDTH-1:0]    duty,
    output logic [1:0]          state,
    output logic                period_end
);

    localparam int unsigned      DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(PERIOD);
    localparam logic [WIDTH:0]   PERIOD_X = (WIDTH + 1)'(PERIOD);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [WIDTH-1:0] cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nx;
    state_t           st_q;
    state_t           st_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] tgt_d;
    logic [WIDTH-1:0] act_q;
    logic             ramping;
    logic             tick;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;

    assign period_end = (cnt == CNT_MAX);
    assign ramping    = (st_q == ST_RAMP_UP) || (st_q == ST_RAMP_DOWN);
    assign tick       = period_end && ramping && (div_cnt == DIV_LAST);

    // One extra bit so saturation can be detected without wrap-around.
    assign up_sum  = {1'b0, tgt_q} + STEP_X;
    assign dn_diff = {1'b0, tgt_q} - STEP_X;

    assign duty  = act_q;
    assign state = st_q;

    // Main period counter: never stalled, independent of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (period_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Ramp divider: counts period ends while ramping, held in HOLD, cleared in IDLE.
    always_comb begin
        div_nx = div_cnt;
        case (st_q)
            ST_IDLE: div_nx = '0;
            ST_RAMP_UP, ST_RAMP_DOWN: begin
                if (period_end) begin
                    div_nx = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
                end
            end
            default: div_nx = div_cnt;
        endcase
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_nx;
        end
    end

    // FSM next state and target duty. The tick's duty update is applied
    // first; a step in the same cycle then overrides only the state, except
    // in HOLD where it also clears the target.
    always_comb begin
        st_d  = st_q;
        tgt_d = tgt_q;
        case (st_q)
            ST_IDLE: begin
                tgt_d = '0;
                if (step) begin
                    st_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (tick) begin
                    if (up_sum >= PERIOD_X) begin
                        tgt_d = CNT_MAX;
                        st_d  = ST_RAMP_DOWN;
                    end else begin
                        tgt_d = up_sum[WIDTH-1:0];
                    end
                end
                if (step) begin
                    st_d = ST_HOLD;
                end
            end
            ST_RAMP_DOWN: begin
                if (tick) begin
                    if (dn_diff[WIDTH] || (dn_diff == '0)) begin
                        tgt_d = '0;
                        st_d  = ST_RAMP_UP;
                    end else begin
                        tgt_d = dn_diff[WIDTH-1:0];
                    end
                end
                if (step) begin
                    st_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (step) begin
                    st_d  = ST_IDLE;
                    tgt_d = '0;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                tgt_d = '0;
            end
        endcase
    end

    // State, target and applied duty; applied duty only loads at period end.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            tgt_q <= '0;
            act_q <= '0;
        end else begin
            st_q  <= st_d;
            tgt_q <= tgt_d;
            if (period_end) begin
                act_q <= tgt_d;
            end
        end
    end

    // One channel per output, each preloaded with its phase offset.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_channel #(
            .WIDTH  (WIDTH),
            .PERIOD (PERIOD),
            .INIT   (phase_offset(k, PHASE, PERIOD))
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .duty (act_q),
            .out  (pwm[k])
        );
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: two instances (phase-shifted RAMP_DIV=2, and
// in-phase RAMP_DIV=1) checked each cycle against a reference model, plus
// directed scenarios with literal expectations.
module tb_pwm_sequencer;

    localparam int P = 15;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_a = 1'b0;
    logic       step_b = 1'b0;
    logic [1:0] pwm_a, pwm_b;
    logic [3:0] duty_a, duty_b;
    logic [1:0] state_a, state_b;
    logic       pe_a, pe_b;

    int n_checks = 0;
    int n_errors = 0;

    pwm_sequencer #(
        .WIDTH(4), .PERIOD(15), .CHANNELS(2), .PHASE(8), .STEP(4), .RAMP_DIV(2)
    ) dut_a (
        .clk(clk), .rst(rst), .step(step_a), .pwm(pwm_a),
        .duty(duty_a), .state(state_a), .period_end(pe_a)
    );

    pwm_sequencer #(
        .WIDTH(4), .PERIOD(15), .CHANNELS(2), .PHASE(0), .STEP(4), .RAMP_DIV(1)
    ) dut_b (
        .clk(clk), .rst(rst), .step(step_b), .pwm(pwm_b),
        .duty(duty_b), .state(state_b), .period_end(pe_b)
    );

    always #5 clk = ~clk;

    // Reference model state. t is the cycle position within the period;
    // channel k's position is derived as (t + k*phase) mod (P+1).
    typedef struct {
        int     t;
        int     st;
        int     tgt;
        int     act;
        int     div;
        bit [1:0] pwm;
    } mdl_t;

    mdl_t ma, mb;
    bit   started = 1'b0;

    function automatic mdl_t mdl_next(input mdl_t m, input bit r, input bit s,
                                      input int rdiv, input int phase);
        mdl_t n;
        bit   pe, ramp, tick;
        n = m;
        if (r) begin
            n.t = 0; n.st = 0; n.tgt = 0; n.act = 0; n.div = 0; n.pwm = '0;
            return n;
        end
        pe   = (m.t == P);
        ramp = (m.st == 1) || (m.st == 2);
        tick = pe && ramp && (((m.div + 1) % rdiv) == 0);
        for (int k = 0; k < 2; k++) begin
            n.pwm[k] = (((m.t + k * phase) % (P + 1)) < m.act);
        end
        n.t = (m.t + 1) % (P + 1);
        if (m.st == 0) n.div = 0;
        else if (pe && ramp) n.div = (m.div + 1) % rdiv;
        if (m.st == 0) begin
            n.tgt = 0;
        end else if (tick && m.st == 1) begin
            n.tgt = (m.tgt + S > P) ? P : m.tgt + S;
            if (n.tgt == P) n.st = 2;
        end else if (tick && m.st == 2) begin
            n.tgt = (m.tgt - S < 0) ? 0 : m.tgt - S;
            if (n.tgt == 0) n.st = 1;
        end
        if (s) begin
            case (m.st)
                0:       n.st = 1;
                1, 2:    n.st = 3;
                default: begin n.st = 0; n.tgt = 0; end
            endcase
        end
        if (pe) n.act = n.tgt;
        return n;
    endfunction

    always @(posedge clk) begin
        ma = mdl_next(ma, rst, step_a, 2, 8);
        mb = mdl_next(mb, rst, step_b, 1, 0);
        if (rst) started = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("a_duty",  duty_a,  ma.act);
            chk("a_state", state_a, ma.st);
            chk("a_pwm",   pwm_a,   ma.pwm);
            chk("a_pend",  pe_a,    (ma.t == P));
            chk("b_duty",  duty_b,  mb.act);
            chk("b_state", state_b, mb.st);
            chk("b_pwm",   pwm_b,   mb.pwm);
            chk("b_pend",  pe_b,    (mb.t == P));
        end
    end

    task automatic wait_change(input bit sel, output int val, output int cyc);
        int start;
        start = sel ? int'(duty_b) : int'(duty_a);
        cyc = 0;
        val = start;
        do begin
            @(negedge clk);
            cyc++;
            val = sel ? int'(duty_b) : int'(duty_a);
        end while (val == start && cyc < 300);
        if (val == start) timeout("duty_change");
    endtask

    task automatic wait_pe();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!pe_a && c < 40);
        if (!pe_a) timeout("period_end");
    endtask

    task automatic pulse_a();
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
    endtask

    task automatic pulse_b();
        step_b = 1'b1;
        @(negedge clk);
        step_b = 1'b0;
    endtask

    int exp_seq[8] = '{4, 8, 12, 15, 11, 7, 3, 0};
    int exp_st[8]  = '{1, 1, 1, 2, 2, 2, 2, 1};
    int exp_b[5]   = '{4, 8, 12, 15, 11};

    initial begin
        int v, c, cnt_pe, bad;
        bit p0[16];
        bit p1[16];
        bit e0[16];

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: outputs stay low, period_end every 16 clk.
        cnt_pe = 0;
        bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (pe_a) cnt_pe++;
            if (pwm_a != 0 || duty_a != 0 || state_a != 0) bad++;
        end
        chk("idle_pe_count", cnt_pe, 4);
        chk("idle_quiet", bad, 0);

        // Ramp up to PERIOD, back down to 0, turn around.
        pulse_a();
        chk("start_state", state_a, 1);
        for (int i = 0; i < 8; i++) begin
            wait_change(1'b0, v, c);
            chk("ramp_duty", v, exp_seq[i]);
            chk("ramp_state", state_a, exp_st[i]);
            if (i > 0) chk("ramp_interval", c, 32);
        end
        wait_change(1'b0, v, c);
        chk("turn_duty4", v, 4);
        chk("turn_interval", c, 32);
        wait_change(1'b0, v, c);
        chk("turn_duty8", v, 8);

        // Waveform at duty 8 over one full period.
        wait_pe();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            p0[i] = pwm_a[0];
            p1[i] = pwm_a[1];
        end
        for (int i = 0; i < 16; i++) e0[i] = (i >= 1 && i <= 8);
        for (int i = 0; i < 16; i++) begin
            chk("wave_ch0", p0[i], e0[i]);
            chk("wave_ch1", p1[i], e0[(i + 8) % 16]);
        end

        // Reset mid-ramp at duty 12.
        @(negedge clk);
        chk("pre_rst_duty", duty_a, 12);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_duty", duty_a, 0);
        chk("rst_state", state_a, 0);
        chk("rst_pwm", pwm_a, 0);
        chk("rst_main_cnt", dut_a.cnt, 0);
        chk("rst_ch0_cnt", dut_a.g_ch[0].u_ch.cnt, 0);
        chk("rst_ch1_cnt", dut_a.g_ch[1].u_ch.cnt, 8);

        // Freeze at 8, hold 10 periods, then turn off.
        pulse_a();
        chk("restart_state", state_a, 1);
        wait_change(1'b0, v, c);
        chk("hold_pre4", v, 4);
        wait_change(1'b0, v, c);
        chk("hold_pre8", v, 8);
        repeat (3) @(negedge clk);
        pulse_a();
        chk("hold_state", state_a, 3);
        chk("hold_duty", duty_a, 8);
        bad = 0;
        repeat (160) begin
            @(negedge clk);
            if (duty_a != 8 || state_a != 3) bad++;
        end
        chk("hold_stable", bad, 0);
        pulse_a();
        chk("off_state", state_a, 0);
        chk("off_duty_until_pe", duty_a, 8);
        wait_pe();
        @(negedge clk);
        chk("off_duty", duty_a, 0);

        // Step coincident with a ramp tick at duty 4.
        pulse_a();
        chk("coinc_start", state_a, 1);
        wait_change(1'b0, v, c);
        chk("coinc_duty4", v, 4);
        wait_pe();
        wait_pe();
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        chk("coinc_state", state_a, 3);
        chk("coinc_duty", duty_a, 8);
        pulse_a();
        chk("coinc_off", state_a, 0);

        // RAMP_DIV=1, PHASE=0 instance: tick every period, channels equal.
        pulse_b();
        chk("b_start", state_b, 1);
        for (int i = 0; i < 5; i++) begin
            wait_change(1'b1, v, c);
            chk("b_ramp_duty", v, exp_b[i]);
            if (i > 0) chk("b_interval", c, 16);
        end
        chk("b_state_down", state_b, 2);
        bad = 0;
        repeat (48) begin
            @(negedge clk);
            if (pwm_b[0] != pwm_b[1]) bad++;
        end
        chk("b_in_phase", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
